uart_tx_queue: RTL and testbench
================================

# uart_tx_queue

Byte-wide transmit queue between the CPU's memory-mapped UART store path and the on-chip UART transmitter. It accepts one byte per cycle from store instructions to the TX data address and buffers up to DEPTH bytes plus one presented byte. It drains them into the transmitter's valid/ready handshake, so the CPU no longer needs to poll `tx_ready` before every store. It also exposes occupancy and flush control to the memory-mapped status logic.

## Interface
- `DEPTH`, 8, storage entries; power of two, ≥2
- `DATA_W`, 8, byte width

- `clk`  in  1  core clock
- `rst`  in  1  reset; synchronous, active-high
- `enq_valid`  in  1  CPU store to TX data address (0x8000_0008) this cycle
- `enq_data`  in  DATA_W  store data [7:0]
- `flush`  in  1  CPU store to TX flush address (0x8000_000C); discards all queued bytes
- `full`  out  1  storage holds DEPTH entries
- `empty`  out  1  storage empty and no byte presented
- `count`  out  $clog2(DEPTH)+1  storage occupancy + presented byte (0..DEPTH+1)
- `tx_data`  out  DATA_W  to UART `data_in`
- `tx_valid`  out  1  to UART `data_in_valid`
- `tx_ready`  in  1  from UART `data_in_ready`
- `drop_count`  out  16  overflow counter (only with `UART_TX_QUEUE_STATS_EN`)

## Operation
- Storage: circular buffer. Write and read pointers are $clog2(DEPTH)+1 bits, and the MSB disambiguates full from empty. Pointers wrap modulo 2·DEPTH.
- Output register holds the presented byte. Drain FSM:
  - IDLE: `tx_valid`=0. If storage is non-empty, load the head into the output register and go to PRESENT. Else, if `enq_valid`, bypass `enq_data` straight into the output register and go to PRESENT.
  - PRESENT: `tx_valid`=1. On `tx_valid && tx_ready`, the byte is transferred:
    - Storage non-empty: load the head, stay in PRESENT.
    - Storage empty and `enq_valid`: bypass `enq_data`, stay in PRESENT.
    - Otherwise: go to IDLE.
- Enqueue is accepted iff `full`=0 at the start of the cycle, unless the byte is bypassed. A write while full is dropped with no state change, even if a dequeue occurs in the same cycle.
- A simultaneous accepted enqueue and head-load leaves storage occupancy unchanged.
- `flush`:
  - Next cycle: pointers equal, output register invalid, state IDLE.
  - Overrides `enq_valid` in the same cycle; that byte is discarded and not counted as a drop.
  - A handshake in the flush cycle still counts as sent.
- `tx_data` is held stable while `tx_valid && !tx_ready`.
- Reset values: pointers 0, IDLE, `tx_valid`=0, `tx_data`=0, `full`=0, `empty`=1, `count`=0, `drop_count`=0. Reset aborts any in-flight presentation and loses all data.

## Timing
- Latency from enqueue at cycle N when the queue is empty: `tx_valid`=1 at N+1 (bypass path).
- Latency from enqueue at cycle N when the queue is non-empty: the byte is written to storage at N+1.
- Back-to-back throughput is 1 byte/cycle when `tx_ready` is held high.
- `full`, `empty` and `count` are derived from registered state only and are valid the cycle after any change. They carry no combinational path from `enq_valid` or `tx_ready`.
- No combinational path from `tx_ready` to `tx_valid` or `tx_data`.

## Configuration
- Macro `UART_TX_QUEUE_STATS_EN`.
- Defined:
  - `drop_count` increments by 1 per dropped enqueue and saturates at 0xFFFF.
  - It is cleared only by `rst`; `flush` does not clear it.
- Undefined: the `drop_count` port and counter are absent, and drops are silent.

## Structure
- Shared header/package `riscv_mmio_defs` holds the UART addresses as constants: control 0x8000_0000, RX data 0x8000_0004, TX data 0x8000_0008, TX flush 0x8000_000C. It also holds the drain FSM state encodings (IDLE=0, PRESENT=1).
- One sub-module, `tx_queue_storage`, contains the DEPTH×DATA_W register array with write port (we, waddr) and asynchronous read of the head. Pointer, FSM and counter logic stays in `uart_tx_queue`.

## Test plan
- Reset, then a single enqueue of 0x41 with `tx_ready`=1 → `tx_valid`=1 with `tx_data`=0x41 next cycle. One cycle later `tx_valid`=0 and `empty`=1.
- `tx_ready`=0, enqueue 0x00..0x08 (nine bytes, DEPTH=8) → `count`=9 and `full`=1. With STATS_EN, a tenth enqueue leaves `count`=9 and sets `drop_count`=1.
- From full, raise `tx_ready`=1 → bytes 0x00..0x08 emerge in order on consecutive cycles, and `tx_data` never changes while stalled.
- Interleaved enqueue and dequeue for 40 cycles (pointer wrap across 2·DEPTH) → output order matches a scoreboard with no loss or duplication.
- `flush` together with `enq_valid`=1 (0x55) while 3 bytes are queued → next cycle `empty`=1, `tx_valid`=0, `drop_count` unchanged, and 0x55 is never emitted.
- Assert `rst` while PRESENT with `tx_ready`=0 → next cycle all outputs are at their reset values, and a later enqueue behaves as after a first reset.

Source files
------------

// File: rtl/uart_tx_queue_pkg.sv
// Shared MMIO definitions for the UART block: register addresses and the
// TX drain FSM state encodings.
package riscv_mmio_defs;

  localparam logic [31:0] UART_CTRL_ADDR     = 32'h8000_0000;
  localparam logic [31:0] UART_RX_DATA_ADDR  = 32'h8000_0004;
  localparam logic [31:0] UART_TX_DATA_ADDR  = 32'h8000_0008;
  localparam logic [31:0] UART_TX_FLUSH_ADDR = 32'h8000_000C;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PRESENT = 1'b1;

endpackage

// File: rtl/uart_tx_queue_if.sv
// CPU-store / UART-transmitter bundle for uart_tx_queue.
// The queue uses the slave modport; the store path plus transmitter side uses master.
interface uart_tx_queue_if #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              enq_valid;
  logic [DATA_W-1:0] enq_data;
  logic              flush;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport slave (
    input  enq_valid, enq_data, flush, tx_ready,
    output full, empty, count, tx_data, tx_valid
  );

  modport master (
    output enq_valid, enq_data, flush, tx_ready,
    input  full, empty, count, tx_data, tx_valid
  );
endinterface

// File: rtl/uart_tx_queue_storage.sv
// DEPTH x DATA_W register array for the TX queue: one write port and an
// asynchronous read of the head entry.
module tx_queue_storage #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DEPTH-1:0][DATA_W-1:0] mem;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_tx_queue.sv
// Byte transmit queue between the CPU UART store path and the UART transmitter.
// Define UART_TX_QUEUE_STATS_EN to add the saturating drop_count port.
module uart_tx_queue
  import riscv_mmio_defs::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic            clk,
  input  logic            rst,
`ifdef UART_TX_QUEUE_STATS_EN
  output logic [15:0]     drop_count,
`endif
  uart_tx_queue_if.slave  q
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wptr, rptr, occ;
  logic [0:0]        state;
  logic [DATA_W-1:0] out_data, head;
  logic              present, fire, can_load, stor_empty, full;
  logic              load_head, bypass, enq_acc;

  // MSB of the pointers separates full (diff == DEPTH) from empty (diff == 0).
  assign occ        = wptr - rptr;
  assign stor_empty = (occ == '0);
  assign full       = (occ == (AW+1)'(DEPTH));
  assign present    = (state == ST_PRESENT);
  assign fire       = present && q.tx_ready;
  assign can_load   = !present || fire;

  assign load_head = can_load && !stor_empty;
  assign bypass    = can_load && stor_empty && q.enq_valid;
  assign enq_acc   = q.enq_valid && !full && !bypass && !q.flush;

  tx_queue_storage #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_storage (
    .clk   (clk),
    .we    (enq_acc),
    .waddr (wptr[AW-1:0]),
    .wdata (q.enq_data),
    .raddr (rptr[AW-1:0]),
    .rdata (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      state    <= ST_IDLE;
      out_data <= '0;
    end else if (q.flush) begin
      // Any handshake this cycle has already completed on the UART side.
      rptr  <= wptr;
      state <= ST_IDLE;
    end else begin
      if (enq_acc) wptr <= wptr + 1'b1;
      if (load_head) begin
        rptr     <= rptr + 1'b1;
        out_data <= head;
        state    <= ST_PRESENT;
      end else if (bypass) begin
        out_data <= q.enq_data;
        state    <= ST_PRESENT;
      end else if (fire) begin
        state <= ST_IDLE;
      end
    end
  end

`ifdef UART_TX_QUEUE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)
      drop_count <= '0;
    else if (q.enq_valid && full && !q.flush && drop_count != 16'hFFFF)
      drop_count <= drop_count + 16'd1;
  end
`endif

  assign q.full     = full;
  assign q.empty    = stor_empty && !present;
  assign q.count    = occ + {{AW{1'b0}}, present};
  assign q.tx_valid = present;
  assign q.tx_data  = out_data;
endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed self-checking bench for uart_tx_queue (DEPTH=8, DATA_W=8).
module tb_uart_tx_queue;
  import riscv_mmio_defs::*;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  uart_tx_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

`ifdef UART_TX_QUEUE_STATS_EN
  logic [15:0] drop_count;
`endif

  uart_tx_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef UART_TX_QUEUE_STATS_EN
    .drop_count (drop_count),
`endif
    .q          (bus.slave)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.enq_valid = 1'b0; bus.enq_data = '0; bus.flush = 1'b0; bus.tx_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %0b want 0", bus.tx_valid); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", bus.tx_data); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", bus.full); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b want 1", bus.empty); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
`ifdef UART_TX_QUEUE_STATS_EN
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_count); end
`endif
  endtask

  task automatic test_single();
    bus.tx_ready = 1'b1; bus.enq_valid = 1'b1; bus.enq_data = 8'h41;
    step();
    bus.enq_valid = 1'b0;
    checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", bus.tx_valid); end
    checks++; if (bus.tx_data !== 8'h41) begin errors++; $display("FAIL single_data got %h want 41", bus.tx_data); end
    checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL single_count got %0d want 1", bus.count); end
    step();
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL single_done_valid got %0b want 0", bus.tx_valid); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL single_done_empty got %0b want 1", bus.empty); end
  endtask

  task automatic test_fill();
    bus.tx_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      bus.enq_valid = 1'b1; bus.enq_data = 8'(i);
      step();
    end
    bus.enq_valid = 1'b0;
    checks++; if (bus.count !== 4'd9) begin errors++; $display("FAIL fill_count got %0d want 9", bus.count); end
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fill_full got %0b want 1", bus.full); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL fill_head got %h want 00", bus.tx_data); end
    bus.enq_valid = 1'b1; bus.enq_data = 8'h99;
    step();
    bus.enq_valid = 1'b0;
    checks++; if (bus.count !== 4'd9) begin errors++; $display("FAIL overflow_count got %0d want 9", bus.count); end
`ifdef UART_TX_QUEUE_STATS_EN
    checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL overflow_drop got %0d want 1", drop_count); end
`endif
  endtask

  task automatic test_drain();
    for (int s = 0; s < 3; s++) begin
      step();
      checks++; if (bus.tx_data !== 8'h00 || bus.tx_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold got valid=%0b data=%h want 1/00", bus.tx_valid, bus.tx_data);
      end
    end
    bus.tx_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'(i)) begin
        errors++; $display("FAIL drain_order[%0d] got valid=%0b data=%h want 1/%h", i, bus.tx_valid, bus.tx_data, 8'(i));
      end
      step();
    end
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL drain_end_valid got %0b want 0", bus.tx_valid); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL drain_end_empty got %0b want 1", bus.empty); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] sb[$];
    bit enq, rdy, acc;
    for (int i = 0; i < 40; i++) begin
      enq = (i % 4) != 3;
      rdy = (i % 3) != 0;
      acc = enq && (sb.size() < DEPTH + 1);
      bus.enq_valid = enq; bus.enq_data = 8'(8'h10 + i); bus.tx_ready = rdy;
      checks++; if (bus.count !== 4'(sb.size())) begin
        errors++; $display("FAIL mix_count[%0d] got %0d want %0d", i, bus.count, sb.size());
      end
      if (bus.tx_valid && rdy) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL mix_spurious[%0d] got %h want none", i, bus.tx_data);
        end else begin
          if (bus.tx_data !== sb[0]) begin
            errors++; $display("FAIL mix_order[%0d] got %h want %h", i, bus.tx_data, sb[0]);
          end
          void'(sb.pop_front());
        end
      end
      if (acc) sb.push_back(8'(8'h10 + i));
      step();
    end
    bus.enq_valid = 1'b0; bus.tx_ready = 1'b1;
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      if (bus.tx_valid) begin
        checks++; if (bus.tx_data !== sb[0]) begin
          errors++; $display("FAIL mix_tail got %h want %h", bus.tx_data, sb[0]);
        end
        void'(sb.pop_front());
      end
      step();
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL mix_timeout got %0d left want 0", sb.size()); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL mix_empty got %0b want 1", bus.empty); end
  endtask

  task automatic test_flush();
    logic [15:0] drops_before;
    drops_before = '0;
`ifdef UART_TX_QUEUE_STATS_EN
    drops_before = drop_count;
`endif
    bus.tx_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      bus.enq_valid = 1'b1; bus.enq_data = 8'(i);
      step();
    end
    checks++; if (bus.count !== 4'd3) begin errors++; $display("FAIL flush_pre_count got %0d want 3", bus.count); end
    bus.flush = 1'b1; bus.enq_data = 8'h55;
    step();
    bus.flush = 1'b0; bus.enq_valid = 1'b0;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL flush_empty got %0b want 1", bus.empty); end
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", bus.tx_valid); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL flush_count got %0d want 0", bus.count); end
`ifdef UART_TX_QUEUE_STATS_EN
    checks++; if (drop_count !== drops_before) begin errors++; $display("FAIL flush_drop got %0d want %0d", drop_count, drops_before); end
`endif
    bus.tx_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      step();
      checks++; if (bus.tx_valid !== 1'b0) begin
        errors++; $display("FAIL flush_leak got valid=%0b data=%h want 0", bus.tx_valid, bus.tx_data);
      end
    end
  endtask

  task automatic test_reset_midflight();
    bus.tx_ready = 1'b0;
    bus.enq_valid = 1'b1; bus.enq_data = 8'h77; step();
    bus.enq_data = 8'h78; step();
    bus.enq_valid = 1'b0;
    checks++; if (bus.tx_valid !== 1'b1 || bus.count !== 4'd2) begin
      errors++; $display("FAIL rst_pre got valid=%0b count=%0d want 1/2", bus.tx_valid, bus.count);
    end
    rst = 1'b1; step(); rst = 1'b0;
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %0b want 0", bus.tx_valid); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL rst_mid_data got %h want 00", bus.tx_data); end
    checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin
      errors++; $display("FAIL rst_mid_flags got empty=%0b full=%0b want 1/0", bus.empty, bus.full);
    end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL rst_mid_count got %0d want 0", bus.count); end
`ifdef UART_TX_QUEUE_STATS_EN
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL rst_mid_drop got %0d want 0", drop_count); end
`endif
    bus.tx_ready = 1'b1; bus.enq_valid = 1'b1; bus.enq_data = 8'h42;
    step();
    bus.enq_valid = 1'b0;
    checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h42) begin
      errors++; $display("FAIL rst_after got valid=%0b data=%h want 1/42", bus.tx_valid, bus.tx_data);
    end
    step();
    checks++; if (bus.tx_valid !== 1'b0 || bus.empty !== 1'b1) begin
      errors++; $display("FAIL rst_after_done got valid=%0b empty=%0b want 0/1", bus.tx_valid, bus.empty);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_drain();
    test_back_to_back();
    test_flush();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
